// File: rtl/multiply_execute_unit.sv
// Multi-cycle unsigned shift-and-add multiply stage sitting on the register file.
// Fetches two operands, iterates WIDTH times, writes the truncated product back.
module multiply_execute_unit #(
    parameter int WIDTH         = 8,
    parameter int ADDRESS_WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    output logic                     ready,
    input  logic [ADDRESS_WIDTH-1:0] rs,
    input  logic [ADDRESS_WIDTH-1:0] rt,
    input  logic [ADDRESS_WIDTH-1:0] rd,
    output logic [ADDRESS_WIDTH-1:0] a0,
    output logic [ADDRESS_WIDTH-1:0] a1,
    input  logic [WIDTH-1:0]         rd0,
    input  logic [WIDTH-1:0]         rd1,
    output logic                     we,
    output logic [ADDRESS_WIDTH-1:0] a2,
    output logic [WIDTH-1:0]         wd,
    output logic                     done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        MUL,
        WB
    } state_t;

    state_t state;
    state_t next;

    logic [ADDRESS_WIDTH-1:0] dest;
    logic [WIDTH-1:0]         mcand;
    logic [WIDTH-1:0]         mplier;
    logic [WIDTH-1:0]         acc;
    logic [CW-1:0]            count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            a0     <= '0;
            a1     <= '0;
            dest   <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else begin
            state <= next;
            case (state)
                IDLE: begin
                    if (start) begin
                        a0   <= rs;
                        a1   <= rt;
                        dest <= rd;
                    end
                end
                FETCH: begin
                    mcand  <= rd0;
                    mplier <= rd1;
                    acc    <= '0;
                    count  <= '0;
                end
                MUL: begin
                    // Bits shifted past WIDTH fall off: product is mod 2^WIDTH.
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        next  = state;
        ready = 1'b0;
        we    = 1'b0;
        done  = 1'b0;
        a2    = '0;
        wd    = '0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    next = FETCH;
                end
            end
            FETCH: begin
                next = MUL;
            end
            MUL: begin
                if (count == LAST) begin
                    next = WB;
                end
            end
            WB: begin
                // Register 0 is hardwired; done still reports completion.
                a2   = dest;
                wd   = acc;
                done = 1'b1;
                we   = (dest != '0);
                next = IDLE;
            end
            default: begin
                next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multiply_execute_unit.sv
// Bench for multiply_execute_unit: register file model, vector table,
// scoreboard of expected writebacks, and multi-cycle corner sequences.
module tb_multiply_execute_unit;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic       ready;
    logic [7:0] rs;
    logic [7:0] rt;
    logic [7:0] rd;
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] rd0;
    logic [7:0] rd1;
    logic       we;
    logic [7:0] a2;
    logic [7:0] wd;
    logic       done;

    logic [7:0] regs [256];
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] rs;
        logic [7:0] rt;
        logic [7:0] rd;
        logic [7:0] va;
        logic [7:0] vb;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0] a2;
        logic [7:0] wd;
        logic       we;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[8];

    multiply_execute_unit #(
        .WIDTH(8),
        .ADDRESS_WIDTH(8)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .start(start),
        .ready(ready),
        .rs(rs),
        .rt(rt),
        .rd(rd),
        .a0(a0),
        .a1(a1),
        .rd0(rd0),
        .rd1(rd1),
        .we(we),
        .a2(a2),
        .wd(wd),
        .done(done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Register file: combinational read, write commits at the clock edge.
    assign rd0 = regs[a0];
    assign rd1 = regs[a1];
    always @(posedge clock) begin
        if (we) regs[a2] = wd;
    end

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: a2 %0h wd %0h",
                             a2, wd);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("wb_cycle", cyc, e.cyc);
                    chk("wb_we", {31'd0, we}, {31'd0, e.we});
                    chk("wb_a2", {24'd0, a2}, {24'd0, e.a2});
                    chk("wb_wd", {24'd0, wd}, {24'd0, e.wd});
                end
            end else begin
                chk("idle_out", {15'd0, we, a2, wd}, 32'd0);
            end
        end
    end

    task automatic issue(input logic [7:0] s,
                         input logic [7:0] t,
                         input logic [7:0] d,
                         input logic [7:0] exp_wd,
                         input bit push);
        int n;
        int k;
        n = 0;
        @(negedge clock);
        while (!ready && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (!ready) chk("accept_timeout", 0, 1);
        rs = s;
        rt = t;
        rd = d;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        k = cyc;
        if (push) sb.push_back('{d, exp_wd, d != 0, k + 9});
        @(negedge clock);
        chk("fetch_a0", {24'd0, a0}, {24'd0, s});
        chk("fetch_a1", {24'd0, a1}, {24'd0, t});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || !ready) && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0 || !ready) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        vecs[0] = '{8'd1,  8'd2,  8'd4,  8'h03, 8'h05, 8'h0f};
        vecs[1] = '{8'd1,  8'd2,  8'd3,  8'hff, 8'hff, 8'h01};
        vecs[2] = '{8'd1,  8'd2,  8'd5,  8'h10, 8'h10, 8'h00};
        vecs[3] = '{8'd7,  8'd8,  8'd9,  8'h0d, 8'h0b, 8'h8f};
        vecs[4] = '{8'd10, 8'd10, 8'd11, 8'h80, 8'h80, 8'h00};
        vecs[5] = '{8'd12, 8'd13, 8'd0,  8'h03, 8'h05, 8'h0f};
        vecs[6] = '{8'd14, 8'd15, 8'd16, 8'hff, 8'h01, 8'hff};
        vecs[7] = '{8'd17, 8'd18, 8'd19, 8'h00, 8'h5a, 8'h00};

        for (int i = 0; i < 256; i++) regs[i] = 8'h00;
        reset_n = 1'b0;
        start = 1'b0;
        rs = 8'h55;
        rt = 8'h66;
        rd = 8'h77;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ready", {31'd0, ready}, 1);
        chk("rst_a0a1", {16'd0, a0, a1}, 0);
        chk("rst_a2wd", {16'd0, a2, wd}, 0);
        chk("rst_we_done", {30'd0, we, done}, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            regs[vecs[i].rs] = vecs[i].va;
            regs[vecs[i].rt] = vecs[i].vb;
            issue(vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].exp, 1);
            drain();
            if (vecs[i].rd != 0) begin
                chk("vec_reg", {24'd0, regs[vecs[i].rd]},
                    {24'd0, vecs[i].exp});
            end
            chk("r0_zero", {24'd0, regs[0]}, 0);
        end

        // Back-to-back dependent ops on r2.
        regs[2] = 8'd7;
        issue(8'd2, 8'd2, 8'd2, 8'd49, 1);
        issue(8'd2, 8'd2, 8'd2, 8'h61, 1);
        drain();
        chk("dep_r2", {24'd0, regs[2]}, 32'h61);

        // Start toggling while busy must be ignored.
        regs[1] = 8'd3;
        regs[2] = 8'd5;
        regs[21] = 8'h77;
        regs[30] = 8'h09;
        regs[31] = 8'h09;
        issue(8'd1, 8'd2, 8'd20, 8'h0f, 1);
        for (int c = 1; c <= 10; c++) begin
            chk("busy_ready", {31'd0, ready}, 0);
            chk("busy_a0", {24'd0, a0}, 1);
            rs = 8'd30;
            rt = 8'd31;
            rd = 8'd21;
            start = c[0];
            @(negedge clock);
        end
        start = 1'b0;
        chk("ready_c11", {31'd0, ready}, 1);
        drain();
        chk("ign_r20", {24'd0, regs[20]}, 32'h0f);
        chk("ign_r21", {24'd0, regs[21]}, 32'h77);

        // Reset in the middle of an operation aborts it.
        regs[6] = 8'haa;
        issue(8'd1, 8'd2, 8'd6, 8'h00, 0);
        repeat (4) @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_ready", {31'd0, ready}, 1);
        chk("abort_we", {30'd0, we, done}, 0);
        chk("abort_a0", {24'd0, a0}, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (15) @(negedge clock);
        chk("abort_r6", {24'd0, regs[6]}, 32'haa);
        issue(8'd1, 8'd2, 8'd6, 8'h0f, 1);
        drain();
        chk("post_r6", {24'd0, regs[6]}, 32'h0f);

        // start held high: a new op every 11 cycles.
        @(negedge clock);
        rs = 8'd1;
        rt = 8'd2;
        rd = 8'd22;
        start = 1'b1;
        @(posedge clock);
        #1;
        k = cyc;
        sb.push_back('{8'd22, 8'h0f, 1'b1, k + 9});
        sb.push_back('{8'd22, 8'h0f, 1'b1, k + 20});
        repeat (13) @(negedge clock);
        start = 1'b0;
        drain();
        chk("held_r22", {24'd0, regs[22]}, 32'h0f);

        repeat (3) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
